// File: rtl/fp_operand_comparator_if.sv
// Operand/result bundle for the FP add/subtract operand comparator.
// Input pair moves on in_valid&in_ready; result moves on out_valid&out_ready.
interface fp_operand_comparator_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Data_X;
    logic [W-1:0] Data_Y;
    logic         add_subt;
    logic         out_valid;
    logic         out_ready;
    logic         eq_ops;
    logic         gt_ops;
    logic         Sgn_A;
    logic         Sgn_B;
    logic         arit_op;
    logic [W-1:0] DMP;
    logic [W-1:0] DmP;

    modport master (
        output in_valid, Data_X, Data_Y, add_subt, out_ready,
        input  in_ready, out_valid, eq_ops, gt_ops, Sgn_A, Sgn_B, arit_op, DMP, DmP
    );

    modport slave (
        input  in_valid, Data_X, Data_Y, add_subt, out_ready,
        output in_ready, out_valid, eq_ops, gt_ops, Sgn_A, Sgn_B, arit_op, DMP, DmP
    );
endinterface

// File: rtl/fp_operand_comparator.sv
// Serial MSB-first magnitude compare of X and Y, CHUNK bits per cycle, with early exit;
// produces eq/gt flags, signs, op select and larger/smaller operands for alignment.
module fp_operand_comparator #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    fp_operand_comparator_if.slave      bus,
    output logic [1:0]                  o_dbg_state
);
    localparam int N  = (W - 1 + CHUNK - 1) / CHUNK;
    localparam int MW = N * CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMP = 2'd1, S_DONE = 2'd2} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic           r_arit;
    logic           r_sgn_a;
    logic           r_sgn_b;
    logic           r_eq;
    logic           r_gt;
    logic [W-1:0]   r_dmp;
    logic [W-1:0]   r_dmp_small;
    logic [IW-1:0]  r_idx;

    logic [MW-1:0]    w_mag_x;
    logic [MW-1:0]    w_mag_y;
    logic [CHUNK-1:0] w_slc_x;
    logic [CHUNK-1:0] w_slc_y;
    logic             w_slc_diff;
    logic             w_slc_gt;

    // Magnitudes zero-extended at the MSB so every slice is a full CHUNK wide.
    assign w_mag_x    = MW'(r_x[W-2:0]);
    assign w_mag_y    = MW'(r_y[W-2:0]);
    assign w_slc_x    = w_mag_x[r_idx*CHUNK +: CHUNK];
    assign w_slc_y    = w_mag_y[r_idx*CHUNK +: CHUNK];
    assign w_slc_diff = (w_slc_x != w_slc_y);
    assign w_slc_gt   = (w_slc_x > w_slc_y);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_CMP;
            S_CMP:   if (w_slc_diff || (r_idx == '0)) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_arit      <= 1'b0;
            r_sgn_a     <= 1'b0;
            r_sgn_b     <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_dmp       <= '0;
            r_dmp_small <= '0;
            r_idx       <= IW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.Data_X;
                        r_y     <= bus.Data_Y;
                        r_arit  <= bus.add_subt;
                        r_sgn_a <= bus.Data_X[W-1];
                        r_sgn_b <= bus.Data_Y[W-1];
                        r_idx   <= IW'(N - 1);
                    end
                end
                S_CMP: begin
                    if (w_slc_diff) begin
                        r_eq        <= 1'b0;
                        r_gt        <= w_slc_gt;
                        r_dmp       <= w_slc_gt ? r_x : r_y;
                        r_dmp_small <= w_slc_gt ? r_y : r_x;
                    end else if (r_idx == '0) begin
                        // Equal magnitudes (including +0 vs -0): X is reported as the larger.
                        r_eq        <= 1'b1;
                        r_gt        <= 1'b0;
                        r_dmp       <= r_x;
                        r_dmp_small <= r_y;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.eq_ops    = r_eq;
    assign bus.gt_ops    = r_gt;
    assign bus.Sgn_A     = r_sgn_a;
    assign bus.Sgn_B     = r_sgn_b;
    assign bus.arit_op   = r_arit;
    assign bus.DMP       = r_dmp;
    assign bus.DmP       = r_dmp_small;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_fp_operand_comparator.sv
// Bench for fp_operand_comparator: directed vectors, backpressure, mid-op reset and
// random pairs checked against an arithmetic reference model.
module tb_fp_operand_comparator;
    localparam int W     = 32;
    localparam int CHUNK = 8;
    localparam int N     = (W - 1 + CHUNK - 1) / CHUNK;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;

    fp_operand_comparator_if #(.W(W)) bus ();

    fp_operand_comparator #(.W(W), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: latency is 1 + number of slices scanned down to the highest differing bit.
    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-2:0] d;
        int p;
        d = x[W-2:0] ^ y[W-2:0];
        if (d == '0) return N + 1;
        p = 0;
        for (int b = 0; b < W - 1; b++) if (d[b]) p = b;
        return N - (p / CHUNK) + 1;
    endfunction

    task automatic check_outs(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic as);
        int unsigned mx;
        int unsigned my;
        mx = 32'(x[W-2:0]);
        my = 32'(y[W-2:0]);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_eq"},    64'(bus.eq_ops),    64'(mx == my));
        check({tag, "_gt"},    64'(bus.gt_ops),    64'(mx > my));
        check({tag, "_sgna"},  64'(bus.Sgn_A),     64'(x[W-1]));
        check({tag, "_sgnb"},  64'(bus.Sgn_B),     64'(y[W-1]));
        check({tag, "_arit"},  64'(bus.arit_op),   64'(as));
        check({tag, "_dmp"},   64'(bus.DMP),       64'((mx >= my) ? x : y));
        check({tag, "_dmps"},  64'(bus.DmP),       64'((mx >= my) ? y : x));
    endtask

    // One full transaction. With keep_next set, a second pair is presented right after
    // acceptance and left valid so it is taken as soon as the block returns to idle.
    task automatic run_txn(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic as, input int bp, input logic keep_next,
                           input logic [W-1:0] nx, input logic [W-1:0] ny, input logic nas);
        int  lat;
        bit  got;
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'(1));
        check({tag, "_idle_valid"}, 64'(bus.out_valid), 64'(0));
        bus.in_valid  = 1'b1;
        bus.Data_X    = x;
        bus.Data_Y    = y;
        bus.add_subt  = as;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        if (keep_next) begin
            bus.Data_X   = nx;
            bus.Data_Y   = ny;
            bus.add_subt = nas;
        end else begin
            bus.in_valid = 1'b0;
            bus.Data_X   = $urandom;
            bus.Data_Y   = $urandom;
            bus.add_subt = 1'($urandom_range(0, 1));
        end
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            lat = c;
            if (bus.out_valid) got = 1'b1;
            else check({tag, "_busy_ready"}, 64'(bus.in_ready), 64'(0));
        end
        check({tag, "_latency"}, 64'(lat), 64'(ref_latency(x, y)));
        check_outs(tag, x, y, as);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check_outs({tag, "_bp"}, x, y, as);
            check({tag, "_bp_ready"}, 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(bus.in_ready),  64'(1));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_eq"},    64'(bus.eq_ops),    64'(0));
        check({tag, "_gt"},    64'(bus.gt_ops),    64'(0));
        check({tag, "_sgna"},  64'(bus.Sgn_A),     64'(0));
        check({tag, "_sgnb"},  64'(bus.Sgn_B),     64'(0));
        check({tag, "_arit"},  64'(bus.arit_op),   64'(0));
        check({tag, "_dmp"},   64'(bus.DMP),       64'(0));
        check({tag, "_dmps"},  64'(bus.DmP),       64'(0));
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int           sl;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.Data_X    = '0;
        bus.Data_Y    = '0;
        bus.add_subt  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_txn("pi_eq",   32'h40490FDB, 32'h40490FDB, 1'b1, 0, 1'b0, '0, '0, 1'b0);
        run_txn("top_lt",  32'h3F800000, 32'h40000000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("low_gt",  32'h3F800001, 32'h3F800000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("zero_pm", 32'h80000000, 32'h00000000, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("mid_gt",  32'hC0123456, 32'h40120000, 1'b1, 0, 1'b0, '0, '0, 1'b0);

        // Backpressure with a new pair held valid during DONE.
        run_txn("bp_a", 32'h41200000, 32'hC1100000, 1'b1, 3, 1'b1,
                32'h00000005, 32'h80000007, 1'b0);
        run_txn("bp_b", 32'h00000005, 32'h80000007, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Reset in the middle of a full-length compare.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Data_X   = 32'hBF000000;
        bus.Data_Y   = 32'h3F000000;
        bus.add_subt = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_emit", 64'(bus.out_valid), 64'(0));
        end
        run_txn("post_rst", 32'h3F000001, 32'hBF000000, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Random pairs; Y is often derived from X so every latency gets exercised.
        for (int t = 0; t < 40; t++) begin
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = $urandom;
                1: ry = {~rx[W-1], rx[W-2:0]};
                default: begin
                    sl = $urandom_range(0, N - 1);
                    ry = rx ^ (32'($urandom_range(1, 255)) << (sl * CHUNK));
                    ry[W-1] = 1'($urandom_range(0, 1));
                end
            endcase
            run_txn("rand", rx, ry, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    1'b0, '0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
